reverse_bits_stream: RTL
========================

# reverse_bits_stream

Parametrised, registered bit-reversal engine with valid/ready streaming handshake and four selectable reorder modes: pass, full-word bit reverse, per-byte bit reverse, and byte-order swap. It sits on datapath streams between a producer and a consumer that need endianness or bit-order conversion, such as serial-link framing and CRC-reflected paths. Throughput is one word per clock, with full backpressure support through a two-entry output skid buffer.

## Interface
Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8 and at least 8.
- COUNT_W, 16, width of the processed-word counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- in_mode  in  2  reorder mode, sampled together with in_data.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  WIDTH  reordered word.
- word_count  out  COUNT_W  number of completed output handshakes (see Configuration).

## Operation
- Modes (in_mode):
  - 00: pass; out = in.
  - 01: full reverse; out[i] = in[WIDTH-1-i].
  - 10: per-byte reverse; each byte k gets out[8k+j] = in[8k+7-j].
  - 11: byte swap; byte k maps to byte WIDTH/8-1-k, with bit order inside each byte unchanged.
  - For WIDTH=8, mode 11 equals mode 00.
- Mode is captured per word. Changing in_mode between words takes effect on the next accepted word. Words already in flight are unaffected.
- The reorder is combinational on the input and is stored into registers. There is no arithmetic.
- Storage is two word registers: OUT (drives out_*) and SKID.
- Accept = in_valid && in_ready. Handshake on the output side = out_valid && out_ready.
- in_ready = !skid_valid. It is a registered flag and does not depend combinationally on out_ready.
- Each cycle:
  - OUT empty, or OUT draining this cycle: OUT loads from SKID if SKID is valid, otherwise from the accepted input. If nothing is available, OUT becomes empty.
  - OUT full and not draining, with an accept this cycle: the word goes into SKID.
  - SKID empties in the cycle it is moved into OUT.
  - Ordering is strictly FIFO; no word is dropped or duplicated.
- Simultaneous accept and drain while SKID is valid: SKID moves to OUT. The new input cannot be accepted that cycle because in_ready=0.
- While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
- Reset values: out_valid=0, out_data=0, in_ready=1 (the first cycle after rst deasserts), SKID empty, word_count=0. in_ready=0 while rst=1.
- Reset mid-stream discards both registers. A word presented on the reset cycle is not accepted.

## Timing
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (1 cycle), provided OUT is free.
- Sustained throughput is 1 word/cycle with out_ready held high.
- Backpressure: after out_ready drops, at most one further word is accepted (into SKID). in_ready then deasserts starting the next cycle.
- in_ready reasserts the cycle after SKID drains.
- Counter increments on the same edge as the output handshake. It wraps from 2^COUNT_W-1 to 0.

## Configuration
- Macro REVERSE_BITS_STREAM_COUNT_EN.
- Defined: word_count is a COUNT_W-bit register, counting output handshakes as described above.
- Undefined: no counter register; the word_count port is still present and tied to 0.
- Data path behaviour is identical in both cases.

## Structure
- Package reverse_bits_pkg contains:
  - Mode constants MODE_PASS=00, MODE_REV=01, MODE_BYTE_REV=10, MODE_BSWAP=11.
  - A pure function reorder(data, mode), parametrised by width, shared with other blocks.
- Sub-module reverse_bits_skid: generic WIDTH two-entry skid buffer (OUT plus SKID registers, handshake logic).
- The top level contains the reorder mux, the skid instance and the optional counter.

## Test plan
- WIDTH=16, mode 01, 0x00F1 -> out 0x8F00 one cycle after accept; mode 00, 0x00F1 -> 0x00F1.
- WIDTH=16, mode 10, 0x0102 -> 0x8040; mode 11, 0x1234 -> 0x3412.
- Back-to-back stream of 0x0001..0x0010 in mode 01, with out_ready toggling 1/0 every cycle -> all 16 words appear in order, each reversed. in_ready is never 1 while SKID is full.
- Hold out_ready=0 with in_valid=1 -> exactly two words accepted, in_ready=0 from the third cycle. out_data is stable; releasing out_ready drains both words in order.
- Assert rst with both registers full -> next cycle out_valid=0, out_data=0, word_count=0. in_ready=1 one cycle after rst deasserts.
- COUNT_W=4 with REVERSE_BITS_STREAM_COUNT_EN defined: 17 handshakes -> word_count=1. With the macro undefined: word_count=0 throughout.

Source files
------------

// File: rtl/reverse_bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reverse_bits_pkg
// Description : Shared reorder mode encodings and the reorder() helper used
//               by reverse_bits_stream and any other block that needs
//               bit/byte order conversion.
//               reorder(data, mode, width) works on a MAX_WIDTH container;
//               only the low `width` bits are significant and the rest of
//               the result is zero. `width` must be a multiple of 8 and
//               no larger than MAX_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
package reverse_bits_pkg;

    localparam int MAX_WIDTH = 512;

    localparam logic [1:0] MODE_PASS     = 2'b00;
    localparam logic [1:0] MODE_REV      = 2'b01;
    localparam logic [1:0] MODE_BYTE_REV = 2'b10;
    localparam logic [1:0] MODE_BSWAP    = 2'b11;

    // Each result bit is selected with a one-hot mask instead of a variable
    // index so the source position can be a plain int. Once width and the
    // loop are constant, the mask folds down to a pure wiring mux per mode.
    function automatic logic [MAX_WIDTH-1:0] reorder(
        input logic [MAX_WIDTH-1:0] data,
        input logic [1:0]           mode,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] result;
        int                   src;
        result = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                case (mode)
                    MODE_PASS:     src = i;
                    MODE_REV:      src = width - 1 - i;
                    MODE_BYTE_REV: src = (i / 8) * 8 + 7 - (i % 8);
                    default:       src = (width / 8 - 1 - i / 8) * 8 + (i % 8);
                endcase
                result[i] = |(data & (MAX_WIDTH'(1) << src));
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reverse_bits_skid.sv
`default_nettype none
// ============================================================================
// Module      : reverse_bits_skid
// Description : Generic two-entry skid buffer. OUT drives the output side;
//               SKID catches the single word accepted while OUT is stalled.
//               in_ready depends only on the SKID flag (and reset), never
//               combinationally on out_ready.
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready/in_data   - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module reverse_bits_skid
    import reverse_bits_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic w_accept;
    logic w_out_free;

    // Gating with rst keeps a word offered during reset from being taken.
    assign in_ready   = !r_skid_valid && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            // SKID always holds the older word, so it wins for FIFO order.
            // An accept cannot coincide with a valid SKID (in_ready=0).
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/reverse_bits_stream.sv
`default_nettype none
// ============================================================================
// Module      : reverse_bits_stream
// Description : Registered bit-reversal engine with valid/ready streaming.
//               Modes: pass, full-word bit reverse, per-byte bit reverse,
//               byte-order swap. The mode travels with each word because the
//               reorder is applied before the word is stored.
//               Optional macro REVERSE_BITS_STREAM_COUNT_EN enables the
//               output-handshake counter; without it word_count reads 0.
// Parameters  : WIDTH   - data width, multiple of 8, 8..MAX_WIDTH
//               COUNT_W - width of word_count
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready/in_data/in_mode - input stream
//               out_valid/out_ready/out_data      - output stream
//               word_count                        - completed output words
// Revision    : 1.0 - initial release
// ============================================================================
module reverse_bits_stream
    import reverse_bits_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] word_count
);

    logic [WIDTH-1:0] w_reordered;

    assign w_reordered = WIDTH'(reorder(MAX_WIDTH'(in_data), in_mode, WIDTH));

    reverse_bits_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_reordered),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifdef REVERSE_BITS_STREAM_COUNT_EN
    logic [COUNT_W-1:0] r_word_count;

    // Wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (out_valid && out_ready) begin
            r_word_count <= r_word_count + COUNT_W'(1);
        end
    end

    assign word_count = r_word_count;
`else
    assign word_count = '0;
`endif

endmodule
`default_nettype wire
